vending_machine: RTL and testbench



---
 rtl/vending_pkg.sv | 23 ++
 rtl/coin_decoder.sv | 23 ++
 rtl/vending_machine.sv | 55 +++++
 tb/tb_vending_machine.sv | 137 +++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared coin codes, default pricing and the credit-state encoding for the
// single-product vending controller.
package vending_pkg;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_INVALID = 2'b11;

    localparam int PRICE_DEF        = 15;
    localparam int NICKEL_VALUE_DEF = 5;
    localparam int DIME_VALUE_DEF   = 10;
    localparam int CREDIT_W_DEF     = 5;

    // Each state is encoded as the credit it represents, so the state register
    // doubles as the credit register.
    typedef enum logic [CREDIT_W_DEF-1:0] {
        C0  = 5'd0,
        C5  = 5'd5,
        C10 = 5'd10
    } credit_state_t;

endpackage

// File: rtl/coin_decoder.sv
// Combinational decode of the per-cycle coin code into a credit increment.
// The invalid code is silently treated as no coin.
module coin_decoder
    import vending_pkg::*;
#(
    parameter int NICKEL_VALUE = NICKEL_VALUE_DEF,
    parameter int DIME_VALUE   = DIME_VALUE_DEF,
    parameter int CREDIT_W     = CREDIT_W_DEF
) (
    input  logic [1:0]          in,
    output logic [CREDIT_W-1:0] coin_value
);

    always_comb begin
        coin_value = '0;
        case (in)
            COIN_NICKEL: coin_value = CREDIT_W'(NICKEL_VALUE);
            COIN_DIME:   coin_value = CREDIT_W'(DIME_VALUE);
            default:     coin_value = '0;
        endcase
    end

endmodule

// File: rtl/vending_machine.sv
// Coin-accumulating vend controller: registers credit and emits a one-cycle
// dispense pulse on the edge that brings credit to PRICE or above.
module vending_machine
    import vending_pkg::*;
#(
    parameter int PRICE        = PRICE_DEF,
    parameter int NICKEL_VALUE = NICKEL_VALUE_DEF,
    parameter int DIME_VALUE   = DIME_VALUE_DEF,
    parameter int CREDIT_W     = CREDIT_W_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] in,
    output logic       out
);

    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W-1:0] sum;
    credit_state_t       state;
    credit_state_t       state_next;
    logic                out_next;

    coin_decoder #(
        .NICKEL_VALUE (NICKEL_VALUE),
        .DIME_VALUE   (DIME_VALUE),
        .CREDIT_W     (CREDIT_W)
    ) u_coin_decoder (
        .in         (in),
        .coin_value (coin_value)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= C0;
            out   <= 1'b0;
        end else begin
            state <= state_next;
            out   <= out_next;
        end
    end

    // Overpayment is discarded: a vend always returns to zero credit.
    always_comb begin
        sum        = CREDIT_W'(state) + coin_value;
        state_next = state;
        out_next   = 1'b0;
        if (sum >= CREDIT_W'(PRICE)) begin
            state_next = C0;
            out_next   = 1'b1;
        end else begin
            state_next = credit_state_t'(sum);
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Directed-vector bench for vending_machine with immediate-assertion checks.
module tb_vending_machine;

    logic       clock;
    logic       reset;
    logic [1:0] in;
    logic       out;

    int vecs;
    int errs;

    vending_machine dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .out   (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one coin for one cycle, then check out 1 ns after the edge.
    task automatic apply(input logic [1:0] coin, input logic exp, input string tag);
        in = coin;
        @(posedge clock);
        #1;
        vecs++;
        assert (out === exp) else begin
            errs++;
            $error("FAIL %s: out=%0b expected %0b", tag, out, exp);
        end
    endtask

    task automatic check_out(input logic exp, input string tag);
        vecs++;
        assert (out === exp) else begin
            errs++;
            $error("FAIL %s: out=%0b expected %0b", tag, out, exp);
        end
    endtask

    task automatic check_credit(input logic [4:0] exp, input string tag);
        logic [4:0] obs;
        obs = dut.state;
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: credit=%0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        vecs  = 0;
        errs  = 0;
        in    = 2'b00;
        reset = 1'b0;

        #12;
        check_out(1'b0, "reset_out");
        check_credit(5'd0, "reset_credit");
        #10 reset = 1'b1;

        apply(2'b00, 1'b0, "idle0");
        apply(2'b00, 1'b0, "idle1");
        apply(2'b00, 1'b0, "idle2");
        check_credit(5'd0, "idle_credit");

        apply(2'b01, 1'b0, "nnn_1");
        apply(2'b01, 1'b0, "nnn_2");
        apply(2'b01, 1'b1, "nnn_3_vend");
        apply(2'b00, 1'b0, "nnn_after");

        apply(2'b01, 1'b0, "nd_1");
        apply(2'b10, 1'b1, "nd_vend");
        apply(2'b00, 1'b0, "nd_after");

        apply(2'b10, 1'b0, "dn_1");
        apply(2'b01, 1'b1, "dn_vend");

        apply(2'b10, 1'b0, "dd_1");
        apply(2'b10, 1'b1, "dd_vend_overpay");
        apply(2'b01, 1'b0, "dd_then_nickel");
        check_credit(5'd5, "no_carry_over");
        apply(2'b10, 1'b1, "c5_dime_vend");

        apply(2'b01, 1'b0, "nnd_1");
        apply(2'b01, 1'b0, "nnd_2");
        apply(2'b10, 1'b1, "nnd_vend");
        apply(2'b00, 1'b0, "nnd_after");
        check_credit(5'd0, "nnd_credit");

        apply(2'b01, 1'b0, "hold_1");
        apply(2'b01, 1'b0, "hold_2");
        apply(2'b01, 1'b1, "hold_3_vend");
        apply(2'b01, 1'b0, "hold_4");
        apply(2'b01, 1'b0, "hold_5");
        apply(2'b01, 1'b1, "hold_6_vend");

        apply(2'b11, 1'b0, "inv_1");
        apply(2'b11, 1'b0, "inv_2");
        apply(2'b11, 1'b0, "inv_3");
        apply(2'b11, 1'b0, "inv_4");
        check_credit(5'd0, "inv_credit0");

        apply(2'b01, 1'b0, "c5_then_inv_a");
        apply(2'b11, 1'b0, "c5_then_inv_b");
        check_credit(5'd5, "inv_keeps_c5");
        apply(2'b01, 1'b0, "c10_reach");
        check_credit(5'd10, "c10_credit");
        apply(2'b10, 1'b1, "c10_dime_vend");
        check_credit(5'd0, "c10_dime_clear");

        // Async reset with credit 10 held, between clock edges.
        apply(2'b10, 1'b0, "rst_c10");
        in = 2'b00;
        #3 reset = 1'b0;
        #1;
        check_out(1'b0, "rst_mid_out");
        check_credit(5'd0, "rst_mid_credit");
        #2 reset = 1'b1;
        apply(2'b01, 1'b0, "rst_then_nickel");
        check_credit(5'd5, "rst_then_c5");

        // Async reset while a dispense pulse is high.
        apply(2'b10, 1'b1, "pulse_vend");
        #3 reset = 1'b0;
        #1;
        check_out(1'b0, "pulse_killed");
        check_credit(5'd0, "pulse_rst_credit");
        #2 reset = 1'b1;
        apply(2'b00, 1'b0, "post_rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
